// File: rtl/map_port_arbiter.sv
// map_port_arbiter
//   Shares one single-port synchronous map ROM between two requesters
//   (0: bot simulator map port, 1: display/video path). One access is
//   accepted per clock. The result returns exactly 2 clocks after the grant.
//   Coordinates outside the map skip the ROM read and return OOB_VAL.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   req0/req1          level-sensitive access requests
//   x0,y0 / x1,y1      8-bit column/row coordinates per requester
//   gnt0/gnt1          one-cycle pulse: request accepted, coordinates captured
//   val0/val1          map value per requester, held until that requester's next vld
//   vld0/vld1          one-cycle pulse: valN carries the read result
//   mem_en, mem_addr   ROM read enable and {row, col} address
//   mem_dout           ROM read data, valid the cycle after the mem_en edge
module map_port_arbiter #(
    parameter int         COL_BITS   = 7,
    parameter int         ROW_BITS   = 7,
    parameter bit         FIXED_PRIO = 1'b0,
    parameter logic [1:0] OOB_VAL    = 2'b10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req0,
    input  logic                         req1,
    input  logic [7:0]                   x0,
    input  logic [7:0]                   y0,
    input  logic [7:0]                   x1,
    input  logic [7:0]                   y1,
    output logic                         gnt0,
    output logic                         gnt1,
    output logic [1:0]                   val0,
    output logic [1:0]                   val1,
    output logic                         vld0,
    output logic                         vld1,
    output logic                         mem_en,
    output logic [ROW_BITS+COL_BITS-1:0] mem_addr,
    input  logic [1:0]                   mem_dout
);

    // 9-bit limits so that an 8-bit coordinate map is also representable
    localparam logic [8:0] COL_LIM = 9'(1) << COL_BITS;
    localparam logic [8:0] ROW_LIM = 9'(1) << ROW_BITS;

    // Requester granted most recently (round-robin pointer)
    typedef enum logic {
        LAST_R0 = 1'b0,
        LAST_R1 = 1'b1
    } last_t;

    last_t      last_q;

    logic       win_valid;
    logic       win_id;
    logic [7:0] sel_x;
    logic [7:0] sel_y;
    logic       sel_in_range;

    // Pipeline tag: stage 1 lines up with the ROM address register,
    // stage 2 with the ROM data output
    logic       tag1_vld, tag1_id, tag1_inr;
    logic       tag2_vld, tag2_id, tag2_inr;

    always_comb begin
        win_valid = req0 | req1;
        win_id    = 1'b0;
        if (req0 && req1) begin
            // tie: fixed priority to 0, or the one not granted last
            win_id = FIXED_PRIO ? 1'b0 : (last_q == LAST_R0);
        end else begin
            win_id = req1;
        end
        sel_x        = win_id ? x1 : x0;
        sel_y        = win_id ? y1 : y0;
        sel_in_range = ({1'b0, sel_x} < COL_LIM) && ({1'b0, sel_y} < ROW_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= LAST_R0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            tag1_vld <= 1'b0;
            tag1_id  <= 1'b0;
            tag1_inr <= 1'b0;
            tag2_vld <= 1'b0;
            tag2_id  <= 1'b0;
            tag2_inr <= 1'b0;
            vld0     <= 1'b0;
            vld1     <= 1'b0;
            val0     <= '0;
            val1     <= '0;
        end else begin
            gnt0   <= win_valid && !win_id;
            gnt1   <= win_valid && win_id;
            mem_en <= win_valid && sel_in_range;
            if (win_valid) begin
                mem_addr <= {sel_y[ROW_BITS-1:0], sel_x[COL_BITS-1:0]};
                last_q   <= win_id ? LAST_R1 : LAST_R0;
            end

            tag1_vld <= win_valid;
            tag1_id  <= win_id;
            tag1_inr <= sel_in_range;
            tag2_vld <= tag1_vld;
            tag2_id  <= tag1_id;
            tag2_inr <= tag1_inr;

            vld0 <= tag2_vld && !tag2_id;
            vld1 <= tag2_vld && tag2_id;
            if (tag2_vld) begin
                if (tag2_id) begin
                    val1 <= tag2_inr ? mem_dout : OOB_VAL;
                end else begin
                    val0 <= tag2_inr ? mem_dout : OOB_VAL;
                end
            end
        end
    end

endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter
//   Directed scenarios plus a randomised scoreboard run for map_port_arbiter.
//   u_rr uses round-robin arbitration, u_fp fixed priority. Both read a
//   bench-owned synchronous ROM image.
module tb_map_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  x0, y0, x1, y1;
    logic        gnt0, gnt1, vld0, vld1, mem_en;
    logic [1:0]  val0, val1, mem_dout;
    logic [13:0] mem_addr;

    logic        fp_req0, fp_req1;
    logic        fp_gnt0, fp_gnt1, fp_vld0, fp_vld1, fp_mem_en;
    logic [1:0]  fp_val0, fp_val1, fp_mem_dout;
    logic [13:0] fp_mem_addr;

    logic [1:0]  rom [0:16383];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    map_port_arbiter #(.COL_BITS(7), .ROW_BITS(7), .FIXED_PRIO(1'b0), .OOB_VAL(2'b10)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .val0(val0), .val1(val1), .vld0(vld0), .vld1(vld1),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    map_port_arbiter #(.COL_BITS(7), .ROW_BITS(7), .FIXED_PRIO(1'b1), .OOB_VAL(2'b10)) u_fp (
        .clk(clk), .reset(reset),
        .req0(fp_req0), .req1(fp_req1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .val0(fp_val0), .val1(fp_val1), .vld0(fp_vld0), .vld1(fp_vld1),
        .mem_en(fp_mem_en), .mem_addr(fp_mem_addr), .mem_dout(fp_mem_dout)
    );

    always @(posedge clk) begin
        if (mem_en)    mem_dout    <= rom[mem_addr];
        if (fp_mem_en) fp_mem_dout <= rom[fp_mem_addr];
    end

    function automatic logic [1:0] rom_at(input logic [7:0] x, input logic [7:0] y);
        logic [13:0] a;
        a = {y[6:0], x[6:0]};
        return rom[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; fp_req0 = 1'b0; fp_req1 = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; fp_req0 = 1'b1; fp_req1 = 1'b1;
        x0 = 8'd1; y0 = 8'd1; x1 = 8'd2; y1 = 8'd2;
        step(); step();
        checks++;
        if ({gnt0, gnt1, vld0, vld1, mem_en} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b want 00000", {gnt0, gnt1, vld0, vld1, mem_en});
        end
        checks++;
        if (mem_addr !== 14'h0) begin
            failures++; $display("FAIL reset_addr: got %h want 0000", mem_addr);
        end
        checks++;
        if ({val0, val1} !== 4'b0) begin
            failures++; $display("FAIL reset_val: got %b want 0000", {val0, val1});
        end
        checks++;
        if ({fp_gnt0, fp_gnt1, fp_vld0, fp_vld1, fp_mem_en} !== 5'b0) begin
            failures++; $display("FAIL reset_fp_ctrl: got %b want 00000", {fp_gnt0, fp_gnt1, fp_vld0, fp_vld1, fp_mem_en});
        end
        req0 = 1'b0; req1 = 1'b0; fp_req0 = 1'b0; fp_req1 = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1'b1; x0 = 8'd5; y0 = 8'd3;
        step();
        checks++;
        if ({gnt0, gnt1, mem_en} !== 3'b101) begin
            failures++; $display("FAIL single_gnt: got gnt0,gnt1,mem_en=%b want 101", {gnt0, gnt1, mem_en});
        end
        checks++;
        if (mem_addr !== 14'h0185) begin
            failures++; $display("FAIL single_addr: got %h want 0185", mem_addr);
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({gnt0, vld0} !== 2'b00) begin
            failures++; $display("FAIL single_gap: got gnt0,vld0=%b want 00", {gnt0, vld0});
        end
        step();
        checks++;
        if ({vld0, vld1, val0} !== 4'b1001) begin
            failures++; $display("FAIL single_vld: got vld0,vld1,val0=%b want 1001", {vld0, vld1, val0});
        end
        step();
        checks++;
        if ({vld0, val0} !== 3'b001) begin
            failures++; $display("FAIL single_hold: got vld0,val0=%b want 001", {vld0, val0});
        end
    endtask

    task automatic test_tie_rr();
        logic [1:0] e0, e1;
        logic       eg0, eg1, ev0, ev1;
        int         j;
        do_reset();
        x0 = 8'd10; y0 = 8'd20; x1 = 8'd30; y1 = 8'd40;
        e0 = rom_at(8'd10, 8'd20);
        e1 = rom_at(8'd30, 8'd40);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            eg1 = (i < 4) && (i % 2 == 0);
            eg0 = (i < 4) && (i % 2 == 1);
            j   = i - 2;
            ev1 = (j >= 0) && (j < 4) && (j % 2 == 0);
            ev0 = (j >= 0) && (j < 4) && (j % 2 == 1);
            checks++;
            if ({gnt0, gnt1} !== {eg0, eg1}) begin
                failures++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {eg0, eg1});
            end
            checks++;
            if ({vld0, vld1} !== {ev0, ev1}) begin
                failures++; $display("FAIL rr_vld[%0d]: got %b want %b", i, {vld0, vld1}, {ev0, ev1});
            end
            if (ev0) begin
                checks++;
                if (val0 !== e0) begin
                    failures++; $display("FAIL rr_val0[%0d]: got %b want %b", i, val0, e0);
                end
            end
            if (ev1) begin
                checks++;
                if (val1 !== e1) begin
                    failures++; $display("FAIL rr_val1[%0d]: got %b want %b", i, val1, e1);
                end
            end
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        // last grant went to 0; an idle edge must leave the pointer alone
        step();
        checks++;
        if ({gnt0, gnt1, mem_en} !== 3'b000) begin
            failures++; $display("FAIL idle: got %b want 000", {gnt0, gnt1, mem_en});
        end
        req0 = 1'b1; req1 = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++; $display("FAIL idle_ptr: got gnt0,gnt1=%b want 01", {gnt0, gnt1});
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_fixed();
        do_reset();
        x0 = 8'd7; y0 = 8'd8; x1 = 8'd9; y1 = 8'd11;
        fp_req0 = 1'b1; fp_req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({fp_gnt0, fp_gnt1} !== 2'b10) begin
                failures++; $display("FAIL fixed_gnt[%0d]: got %b want 10", i, {fp_gnt0, fp_gnt1});
            end
        end
        fp_req0 = 1'b0;
        step();
        checks++;
        if ({fp_gnt0, fp_gnt1} !== 2'b01) begin
            failures++; $display("FAIL fixed_release: got %b want 01", {fp_gnt0, fp_gnt1});
        end
        fp_req1 = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_oob();
        do_reset();
        req1 = 1'b1; x1 = 8'd200; y1 = 8'd10;
        step();
        checks++;
        if ({gnt0, gnt1, mem_en} !== 3'b010) begin
            failures++; $display("FAIL oob_x_gnt: got gnt0,gnt1,mem_en=%b want 010", {gnt0, gnt1, mem_en});
        end
        // row out of range from the other requester, back to back
        req1 = 1'b0; req0 = 1'b1; x0 = 8'd5; y0 = 8'd128;
        step();
        checks++;
        if ({gnt0, gnt1, mem_en} !== 3'b100) begin
            failures++; $display("FAIL oob_y_gnt: got gnt0,gnt1,mem_en=%b want 100", {gnt0, gnt1, mem_en});
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({vld0, vld1, val1} !== 4'b0110) begin
            failures++; $display("FAIL oob_x_vld: got vld0,vld1,val1=%b want 0110", {vld0, vld1, val1});
        end
        step();
        checks++;
        if ({vld0, vld1, val0} !== 4'b1010) begin
            failures++; $display("FAIL oob_y_vld: got vld0,vld1,val0=%b want 1010", {vld0, vld1, val0});
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req0 = 1'b1; x0 = 8'd1; y0 = 8'd1;
        step();
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++; $display("FAIL mid_gnt: got %b want 1", gnt0);
        end
        req0 = 1'b0; reset = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1, vld0, vld1, mem_en, mem_addr, val0, val1} !== 23'b0) begin
            failures++; $display("FAIL mid_reset_outs: got %b want 0", {gnt0, gnt1, vld0, vld1, mem_en, mem_addr, val0, val1});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({vld0, vld1} !== 2'b00) begin
                failures++; $display("FAIL mid_no_vld[%0d]: got %b want 00", i, {vld0, vld1});
            end
        end
        req0 = 1'b1; req1 = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++; $display("FAIL mid_tie: got gnt0,gnt1=%b want 01", {gnt0, gnt1});
        end
        req0 = 1'b0; req1 = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] ev [0:2];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                req0 = 1'b1; x0 = 8'(i * 17 + 2); y0 = 8'(i * 29 + 1);
                ev[i] = rom_at(x0, y0);
            end else begin
                req0 = 1'b0;
            end
            step();
            checks++;
            if (gnt0 !== (i < 3)) begin
                failures++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, gnt0, (i < 3));
            end
            if (i >= 2) begin
                checks++;
                if ({vld0, val0} !== {1'b1, ev[i-2]}) begin
                    failures++; $display("FAIL b2b_vld[%0d]: got vld0,val0=%b want %b", i, {vld0, val0}, {1'b1, ev[i-2]});
                end
            end
        end
    endtask

    task automatic test_stress();
        logic       last;
        logic       w_v, w_id;
        logic [1:0] w_val;
        logic       p1_v, p1_id, p2_v, p2_id;
        logic [1:0] p1_val, p2_val;
        do_reset();
        last = 1'b0;
        p1_v = 1'b0; p1_id = 1'b0; p1_val = '0;
        p2_v = 1'b0; p2_id = 1'b0; p2_val = '0;
        for (int n = 0; n < 10000; n++) begin
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            x0 = 8'($urandom_range(0, 140)); y0 = 8'($urandom_range(0, 140));
            x1 = 8'($urandom_range(0, 140)); y1 = 8'($urandom_range(0, 140));
            w_v  = req0 | req1;
            w_id = (req0 && req1) ? ~last : req1;
            if (w_v) last = w_id;
            if (w_id) w_val = (x1 < 8'd128 && y1 < 8'd128) ? rom_at(x1, y1) : 2'b10;
            else      w_val = (x0 < 8'd128 && y0 < 8'd128) ? rom_at(x0, y0) : 2'b10;
            step();
            checks++;
            if ({gnt0, gnt1} !== {w_v && !w_id, w_v && w_id}) begin
                failures++; $display("FAIL stress_gnt[%0d]: got %b want %b", n, {gnt0, gnt1}, {w_v && !w_id, w_v && w_id});
            end
            checks++;
            if ({vld0, vld1} !== {p2_v && !p2_id, p2_v && p2_id}) begin
                failures++; $display("FAIL stress_vld[%0d]: got %b want %b", n, {vld0, vld1}, {p2_v && !p2_id, p2_v && p2_id});
            end
            if (p2_v) begin
                checks++;
                if ((p2_id ? val1 : val0) !== p2_val) begin
                    failures++; $display("FAIL stress_val[%0d]: got %b want %b (req %0d)", n, (p2_id ? val1 : val0), p2_val, p2_id);
                end
            end
            p2_v = p1_v; p2_id = p1_id; p2_val = p1_val;
            p1_v = w_v;  p1_id = w_id;  p1_val = w_val;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            rom[i] = 2'(i ^ (i >> 5));
        end
        rom[14'h0185] = 2'b01;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; fp_req0 = 1'b0; fp_req1 = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;

        test_reset();
        test_single();
        test_tie_rr();
        test_fixed();
        test_oob();
        test_reset_midflight();
        test_back_to_back();
        test_stress();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
